// File: rtl/bka_sub_pkg.sv
// Shared definitions for the bit-serial Brent-Kung subtractor: slice width,
// default modulus and the controller state encoding.
package bka_sub_pkg;

    localparam int SLICE_W       = 4;
    localparam int MOD_Q_DEFAULT = 12289;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SUB  = 2'd1,
        FIX  = 2'd2,
        DONE = 2'd3
    } state_t;

endpackage

// File: rtl/bka_sub_slice4.sv
// One 4-bit Brent-Kung prefix adder with carry-in and carry-out. The top
// module time-shares a single instance across every slice of an operand.
module bka_sub_slice4
    import bka_sub_pkg::*;
(
    input  logic [SLICE_W-1:0] i_a,
    input  logic [SLICE_W-1:0] i_b,
    input  logic               i_cin,
    output logic [SLICE_W-1:0] o_sum,
    output logic               o_cout
);

    logic [3:0] w_g;
    logic [3:0] w_p;
    logic       w_g10;
    logic       w_p10;
    logic       w_g32;
    logic       w_p32;
    logic       w_g30;
    logic       w_p30;
    logic [4:0] w_c;

    assign w_g = i_a & i_b;
    assign w_p = i_a ^ i_b;

    // Up-sweep: pairwise group generate/propagate, then the full span.
    assign w_g10 = w_g[1] | (w_p[1] & w_g[0]);
    assign w_p10 = w_p[1] & w_p[0];
    assign w_g32 = w_g[3] | (w_p[3] & w_g[2]);
    assign w_p32 = w_p[3] & w_p[2];
    assign w_g30 = w_g32 | (w_p32 & w_g10);
    assign w_p30 = w_p32 & w_p10;

    // Down-sweep: carry-in folded into each prefix; bit 2 fills the gap.
    assign w_c[0] = i_cin;
    assign w_c[1] = w_g[0] | (w_p[0] & i_cin);
    assign w_c[2] = w_g10  | (w_p10  & i_cin);
    assign w_c[3] = w_g[2] | (w_p[2] & w_c[2]);
    assign w_c[4] = w_g30  | (w_p30  & i_cin);

    assign o_sum  = w_p ^ w_c[3:0];
    assign o_cout = w_c[4];

endmodule

// File: rtl/bka_serial_subtractor.sv
// Bit-serial unsigned subtractor: D = A + ~B + 1, four bits per cycle
// LSB-first through one shared Brent-Kung slice, valid/ready on both sides.
// Optional feature: define BKA_SUB_MOD_EN to add MOD_Q back in a FIX pass
// whenever the raw subtraction borrows, giving (A - B) mod MOD_Q.
module bka_serial_subtractor
    import bka_sub_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int MOD_Q = MOD_Q_DEFAULT
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             valid_i,
    output logic             ready_o,
    input  logic [WIDTH-1:0] A_i,
    input  logic [WIDTH-1:0] B_i,
    output logic             valid_o,
    input  logic             ready_i,
    output logic [WIDTH-1:0] D_o,
    output logic             borrow_o
);

    localparam int N     = WIDTH / SLICE_W;
    localparam int CNT_W = (N > 1) ? $clog2(N) : 1;

    // Elaboration-time guard on the operand width and modulus.
    generate
        if ((WIDTH % SLICE_W) != 0 || WIDTH < 8 || MOD_Q < 2) begin : g_param_check
            $error("bka_serial_subtractor: WIDTH must be a multiple of 4 and >= 8, MOD_Q >= 2");
        end
    endgenerate

    state_t             r_state;
    state_t             w_state_next;
    logic [WIDTH-1:0]   r_a;
    logic [WIDTH-1:0]   r_b;
    logic [WIDTH-1:0]   r_d;
    logic               r_carry;
    logic [CNT_W-1:0]   r_cnt;
    logic               r_borrow;

    logic               w_last;
    logic [SLICE_W-1:0] w_b_slice;
    logic [SLICE_W-1:0] w_sum;
    logic               w_cout;
    logic [WIDTH-1:0]   w_d_shift;

    assign w_last    = (r_cnt == CNT_W'(N - 1));
    assign w_d_shift = {w_sum, r_d[WIDTH-1:SLICE_W]};

`ifdef BKA_SUB_MOD_EN
    // Subtract pass feeds ~B; the correction pass adds MOD_Q unmodified.
    assign w_b_slice = (r_state == SUB) ? ~r_b[SLICE_W-1:0] : r_b[SLICE_W-1:0];
`else
    assign w_b_slice = ~r_b[SLICE_W-1:0];
`endif

    bka_sub_slice4 u_slice (
        .i_a    (r_a[SLICE_W-1:0]),
        .i_b    (w_b_slice),
        .i_cin  (r_carry),
        .o_sum  (w_sum),
        .o_cout (w_cout)
    );

    // State register.
    always_ff @(posedge clk_i) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples the pre-edge values regardless of block order.
        if (rst_i) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state decode and handshake outputs.
    always_comb begin
        // NOTE: every output gets a default first so no path leaves one
        // unassigned, which would otherwise infer a latch.
        w_state_next = r_state;
        ready_o      = 1'b0;
        valid_o      = 1'b0;
        case (r_state)
            IDLE: begin
                ready_o = 1'b1;
                if (valid_i) begin
                    w_state_next = SUB;
                end
            end
            SUB: begin
                if (w_last) begin
`ifdef BKA_SUB_MOD_EN
                    w_state_next = w_cout ? DONE : FIX;
`else
                    w_state_next = DONE;
`endif
                end
            end
`ifdef BKA_SUB_MOD_EN
            FIX: begin
                if (w_last) begin
                    w_state_next = DONE;
                end
            end
`endif
            DONE: begin
                valid_o = 1'b1;
                if (ready_i) begin
                    w_state_next = IDLE;
                end
            end
            default: w_state_next = IDLE;
        endcase
    end

    // Operand capture, per-slice shift of operands/result, carry and borrow.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_a      <= '0;
            r_b      <= '0;
            r_d      <= '0;
            r_carry  <= 1'b0;
            r_cnt    <= '0;
            r_borrow <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (valid_i) begin
                        r_a     <= A_i;
                        r_b     <= B_i;
                        r_carry <= 1'b1;
                        r_cnt   <= '0;
                    end
                end
                SUB, FIX: begin
                    r_a     <= r_a >> SLICE_W;
                    r_b     <= r_b >> SLICE_W;
                    r_d     <= w_d_shift;
                    r_carry <= w_cout;
                    r_cnt   <= w_last ? '0 : r_cnt + 1'b1;
                    if (r_state == SUB && w_last) begin
                        r_borrow <= ~w_cout;
`ifdef BKA_SUB_MOD_EN
                        // Raw borrow: replay the wrapped difference with +MOD_Q.
                        if (!w_cout) begin
                            r_a     <= w_d_shift;
                            r_b     <= WIDTH'(MOD_Q);
                            r_carry <= 1'b0;
                        end
`endif
                    end
                end
                default: ;
            endcase
        end
    end

    assign D_o      = r_d;
    assign borrow_o = r_borrow;

endmodule
